// File: rtl/adrv9001_tdd_seq.sv
// Multi-channel TDD enable sequencer: turns per-channel requests into timed chip-enable and SSI data-enable.
// Optional per-channel burst statistics are compiled in with ADRV9001_TDD_SEQ_STATS_EN.
module adrv9001_tdd_seq #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic [NUM_CH-1:0]             tdd_req,
   input  logic [NUM_CH-1:0]             ch_mask,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ssi_enable_cnt,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ssi_disable_cnt,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   disable_cnt,
   output logic [NUM_CH-1:0]             enable,
   output logic [NUM_CH-1:0]             ssi_en,
   output logic [NUM_CH*3-1:0]           state,
   output logic                          busy
`ifdef ADRV9001_TDD_SEQ_STATS_EN
   ,
   input  logic                          stats_clr,
   output logic [NUM_CH*16-1:0]          burst_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RAMP     = 3'd1,
      ACTIVE   = 3'd2,
      SSI_HOLD = 3'd3,
      DIS_HOLD = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [NUM_CH-1:0] busy_v;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic                 req;
      state_t               st_q, st_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 en_q, en_d;
      logic                 ssi_q, ssi_d;

      assign req = tdd_req[g] & ch_mask[g];

      // Delay fields are sampled only on state entry; the running counter is private afterwards.
      always_comb begin
         st_d  = st_q;
         cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
         case (st_q)
            IDLE: begin
               if (req) begin
                  st_d  = RAMP;
                  cnt_d = ssi_enable_cnt[g*CNT_WIDTH +: CNT_WIDTH];
               end
            end
            RAMP: begin
               if (!req) begin
                  st_d  = DIS_HOLD;
                  cnt_d = disable_cnt[g*CNT_WIDTH +: CNT_WIDTH];
               end else if (cnt_q == '0) begin
                  st_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (!req) begin
                  st_d  = SSI_HOLD;
                  cnt_d = ssi_disable_cnt[g*CNT_WIDTH +: CNT_WIDTH];
               end
            end
            SSI_HOLD: begin
               if (req) begin
                  st_d = ACTIVE;
               end else if (cnt_q == '0) begin
                  st_d  = DIS_HOLD;
                  cnt_d = disable_cnt[g*CNT_WIDTH +: CNT_WIDTH];
               end
            end
            DIS_HOLD: begin
               // Minimum off window: requests are ignored until the hold expires.
               if (cnt_q == '0) st_d = IDLE;
            end
            default: st_d = IDLE;
         endcase
         en_d  = (st_d != IDLE);
         ssi_d = (st_d == ACTIVE) || (st_d == SSI_HOLD);
      end

      always_ff @(posedge s_axi_aclk) begin
         if (!s_axi_aresetn) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            en_q  <= 1'b0;
            ssi_q <= 1'b0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
            ssi_q <= ssi_d;
         end
      end

      assign enable[g]         = en_q;
      assign ssi_en[g]         = ssi_q;
      assign state[g*3 +: 3]   = st_q;
      assign busy_v[g]         = (st_q != IDLE);

`ifdef ADRV9001_TDD_SEQ_STATS_EN
      logic [15:0] burst_q;

      // Clear has priority over a coincident RAMP entry.
      always_ff @(posedge s_axi_aclk) begin
         if (!s_axi_aresetn || stats_clr) begin
            burst_q <= '0;
         end else if (st_q == IDLE && st_d == RAMP) begin
            burst_q <= burst_q + 16'd1;
         end
      end

      assign burst_cnt[g*16 +: 16] = burst_q;
`endif
   end

   assign busy = |busy_v;

endmodule

// File: doc/adrv9001_tdd_seq.md
Name: adrv9001_tdd_seq

Overview:
- Parametrised, multi-channel TDD enable sequencer for the ADRV9001 datapath.
- Generalises the per-channel enable/SSI timing inside the RX/TX channel blocks into one shared block with NUM_CH independent channels.
- Each channel turns a TDD request (register bit OR PL enable) into a timed chip-enable (rxN_en/txN_en pin) and an SSI data-enable (gates tvalid/tready).
- Programmable SSI turn-on delay, SSI turn-off delay and chip-disable delay; per-channel mask and state readback.

Parameters:
- NUM_CH, 4, number of independent channels (RX1, RX2, TX1, TX2 by default); 1..8.
- CNT_WIDTH, 32, width of each delay count field.

Ports:
- s_axi_aclk  in  1  single clock for all logic.
- s_axi_aresetn  in  1  synchronous reset, active-low.
- tdd_req  in  NUM_CH  per-channel request, already synchronous to s_axi_aclk.
- ch_mask  in  NUM_CH  1 = channel allowed to run; 0 = channel request treated as 0.
- ssi_enable_cnt  in  NUM_CH*CNT_WIDTH  per-channel delay from enable high to SSI enable high; channel i is in bits [i*CNT_WIDTH +: CNT_WIDTH].
- ssi_disable_cnt  in  NUM_CH*CNT_WIDTH  per-channel delay from request low to SSI enable low.
- disable_cnt  in  NUM_CH*CNT_WIDTH  per-channel delay from SSI enable low to enable low.
- enable  out  NUM_CH  chip enable to the device pins.
- ssi_en  out  NUM_CH  SSI data enable to the datapath.
- state  out  NUM_CH*3  per-channel FSM state code.
- busy  out  1  OR over all channels of (state != IDLE).

Behaviour:
- Reset (s_axi_aresetn=0 sampled on a rising edge):
  - all FSMs go to IDLE; enable=0, ssi_en=0, state=0, busy=0, counters=0.
  - Reset mid-sequence drops enable and ssi_en on the same edge.
- Effective request: req_i = tdd_req[i] & ch_mask[i].
- Per-channel FSM states (code): IDLE(0), RAMP(1), ACTIVE(2), SSI_HOLD(3), DIS_HOLD(4).
- Counter rule:
  - On entry to RAMP, SSI_HOLD or DIS_HOLD, the channel counter loads the relevant count field, sampled in the entry cycle.
  - The counter decrements every cycle. The state exits in the cycle the counter equals 0, so the state lasts N+1 cycles for count N.
  - Later changes to a count field do not affect a state already in progress.
- IDLE: enable=0, ssi_en=0. If req_i=1, go to RAMP and load ssi_enable_cnt.
- RAMP: enable=1, ssi_en=0.
  - Counter==0 and req_i=1: go to ACTIVE.
  - req_i=0 at any time: go to DIS_HOLD and load disable_cnt; SSI is never enabled.
- ACTIVE: enable=1, ssi_en=1. If req_i=0, go to SSI_HOLD and load ssi_disable_cnt.
- SSI_HOLD: enable=1, ssi_en=1.
  - req_i returns to 1: go back to ACTIVE; ssi_en never glitches low.
  - Otherwise, at counter==0: go to DIS_HOLD and load disable_cnt.
- DIS_HOLD: enable=1, ssi_en=0.
  - Always runs to completion; req_i is ignored. This guarantees a minimum off window.
  - At counter==0: go to IDLE.
  - A request still high on return to IDLE starts a new RAMP on the next cycle.
- Outputs are registered; enable, ssi_en and state change on the clock edge of the state transition.
- Timing from a rising edge of req_i:
  - enable rises 1 cycle after the edge.
  - ssi_en rises ssi_enable_cnt+2 cycles after the edge.
- Timing from a falling edge of req_i in ACTIVE:
  - ssi_en falls ssi_disable_cnt+2 cycles after the edge.
  - enable falls disable_cnt+1 cycles after ssi_en falls.
- Clearing a ch_mask bit behaves exactly like that channel's request falling; it is not an abort.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Count value all-ones is legal; there is no wrap and no saturation issue, because the counter only counts down to 0.

Optional Feature:
- Macro: ADRV9001_TDD_SEQ_STATS_EN.
- Defined:
  - Adds output burst_cnt (NUM_CH*16): a per-channel 16-bit count of IDLE->RAMP entries.
  - Increments in the cycle RAMP is entered, wraps 0xFFFF->0x0000, and resets to 0.
  - Adds input stats_clr (1): synchronous clear of all counters. If a clear and an increment land in the same cycle, the result is 0.
- Undefined: no burst_cnt or stats_clr ports and no counter logic.

Test Plan:
- Basic sequence, ch0: ssi_enable_cnt=3, ssi_disable_cnt=2, disable_cnt=4; tdd_req[0] high at cycle 10, low at cycle 30 -> enable rises at 11; ssi_en rises at 15; ssi_en falls at 34; enable falls at 39; state returns to 0 at 39.
- Abort in RAMP, ch1: ssi_enable_cnt=10; req high for 3 cycles -> ssi_en stays 0 throughout; DIS_HOLD lasts disable_cnt+1 cycles; enable then drops.
- Re-assert in SSI_HOLD, ch2: ssi_disable_cnt=8; req low for 4 cycles then high -> ssi_en and enable stay continuously 1; state goes 2->3->2.
- Reset mid-ACTIVE with all 4 channels ACTIVE -> s_axi_aresetn=0 for 1 cycle gives enable=0, ssi_en=0, busy=0 on that edge; no activity while reset is held.
- Mask and zero counts: all counts 0; ch_mask=4'b1010; tdd_req=4'b1111 -> only ch1 and ch3 sequence; ssi_en rises 2 cycles after req; channels 0 and 2 stay IDLE.
- STATS_EN build: 3 bursts on ch3, then stats_clr coincident with a 4th RAMP entry -> burst_cnt[ch3] reads 3, then 0; preload to 0xFFFF and run 1 burst -> reads 0.
